// File: rtl/score_digits_pkg.sv
// Shared constants for the score digit renderer: glyph geometry, the 3x5
// digit font and the conversion state encoding.
package score_digits_pkg;

  localparam int unsigned GLYPH_W    = 4;
  localparam int unsigned GLYPH_H    = 5;
  localparam int unsigned GLYPH_BITS = 15;

  // Each entry is {col0 row0..row4, col1 row0..row4, col2 row0..row4}.
  localparam logic [9:0][GLYPH_BITS-1:0] GLYPH_TBL = {
    15'b11101_10101_11111,  // 9
    15'b11111_10101_11111,  // 8
    15'b10001_10110_11000,  // 7
    15'b11111_10101_10111,  // 6
    15'b11101_10101_10111,  // 5
    15'b11100_00100_11111,  // 4
    15'b10101_10101_11111,  // 3
    15'b10111_10101_11101,  // 2
    15'b00000_00000_11111,  // 1
    15'b11111_10001_11111   // 0
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // 10^n, used to derive the saturation threshold at elaboration time.
  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

endpackage

// File: rtl/score_digits_render_glyph_rom.sv
// Combinational 3x5 digit font lookup: (nibble, column, row) -> pixel.
module glyph_rom_5x4
  import score_digits_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic [1:0] i_col,
  input  logic [2:0] i_row,
  output logic       o_pix_c
);

  logic [GLYPH_BITS-1:0] w_glyph;
  logic [3:0]            w_idx;
  logic                  w_in_cell;

  // Select the glyph word and the bit addressed by column/row.
  always_comb begin
    w_glyph   = '1;
    if (i_nibble <= 4'd9) w_glyph = GLYPH_TBL[i_nibble];
    w_in_cell = (32'(i_col) < GLYPH_W - 1) && (32'(i_row) < GLYPH_H);
    w_idx     = 4'(GLYPH_BITS - 1) - (4'(i_col) * 4'd5 + 4'(i_row));
    o_pix_c   = 1'b0;
    if (w_in_cell) o_pix_c = w_glyph[w_idx];
  end

endmodule

// File: rtl/score_digits_render.sv
// Score display block: double-dabble binary->BCD conversion into a committed
// display register, plus a registered glyph pixel lookup for the video path.
// Optional feature: define SCORE_LEAD_ZERO_BLANK_EN to blank leading zeros.
module score_digits_render
  import score_digits_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              score_valid,
  input  logic [SCORE_W-1:0]                                score,
  output logic                                              score_ready,
  output logic                                              busy,
  output logic                                              done,
  output logic [4*NUM_DIGITS-1:0]                           bcd,
  input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
  input  logic [1:0]                                        pix_col,
  input  logic [2:0]                                        pix_row,
  output logic                                              pix_on
);

  localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
  localparam int unsigned DSEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W     = $clog2(SCORE_W + 1);
  localparam logic [31:0] SAT_LIMIT = pow10(NUM_DIGITS);

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [BCD_W-1:0]   r_bcd_sr;
  logic [BCD_W-1:0]   r_disp;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_pix;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shift;
  logic [3:0]         w_nib;
  logic               w_sel_ok;
  logic               w_blank;
  logic               w_rom_pix;

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the score MSB.
  always_comb begin
    w_adj = r_bcd_sr;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd_sr[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd_sr[4*d +: 4] + 4'd3;
    end
    w_shift = {w_adj[BCD_W-2:0], r_score[SCORE_W-1]};
  end

  // Conversion state machine; display register only changes in COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_score  <= '0;
      r_bcd_sr <= '0;
      r_disp   <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (score_valid) begin
            r_score  <= score;
            r_sat    <= (32'(score) >= SAT_LIMIT);
            r_bcd_sr <= '0;
            r_cnt    <= CNT_W'(SCORE_W);
            r_state  <= CONVERT;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        CONVERT: begin
          r_bcd_sr <= w_shift;
          r_score  <= r_score << 1;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= COMMIT;
        end
        COMMIT: begin
          r_disp  <= r_sat ? {NUM_DIGITS{4'h9}} : r_bcd_sr;
          r_done  <= 1'b1;
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pick the committed nibble for the digit being drawn.
  always_comb begin
    w_nib    = 4'd0;
    w_sel_ok = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_sel == DSEL_W'(d)) begin
        w_nib    = r_disp[4*d +: 4];
        w_sel_ok = 1'b1;
      end
    end
  end

`ifdef SCORE_LEAD_ZERO_BLANK_EN
  logic w_upper_nz;

  // A digit is blank when it and every digit above it are zero; digit 0 always drawn.
  always_comb begin
    w_upper_nz = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if ((DSEL_W'(d) >= digit_sel) && (r_disp[4*d +: 4] != 4'd0)) w_upper_nz = 1'b1;
    end
    w_blank = (digit_sel != '0) && !w_upper_nz;
  end
`else
  assign w_blank = 1'b0;
`endif

  glyph_rom_5x4 u_glyph_rom (
    .i_nibble (w_nib),
    .i_col    (pix_col),
    .i_row    (pix_row),
    .o_pix_c  (w_rom_pix)
  );

  // Registered pixel output, one cycle after the pixel coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pix <= 1'b0;
    else        r_pix <= w_sel_ok && !w_blank && w_rom_pix;
  end

  assign score_ready = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bcd         = r_disp;
  assign pix_on      = r_pix;

endmodule

// File: tb/tb_score_digits_render.sv
// Directed bench for score_digits_render: vector table of conversions with
// pixel probes, plus hand sequences for reset, busy rejection and blanking.
module tb_score_digits_render;

  localparam int unsigned ND = 4;
  localparam int unsigned SW = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            score_valid = 1'b0;
  logic [SW-1:0]   score = '0;
  logic            score_ready;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] bcd;
  logic [1:0]      digit_sel = 2'd0;
  logic [1:0]      pix_col = 2'd0;
  logic [2:0]      pix_row = 3'd0;
  logic            pix_on;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  score_digits_render #(.NUM_DIGITS(ND), .SCORE_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score_valid (score_valid),
    .score       (score),
    .score_ready (score_ready),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .digit_sel   (digit_sel),
    .pix_col     (pix_col),
    .pix_row     (pix_row),
    .pix_on      (pix_on)
  );

  typedef struct {
    logic [SW-1:0] val;
    logic [15:0]   exp_bcd;
    logic [1:0]    sel;
    logic [1:0]    col;
    logic [2:0]    row;
    logic          exp_pix;
    logic          lead;     // probe lands on a leading-zero digit
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one score and return cycles from the accept edge to done (-1 on timeout).
  task automatic convert(input logic [SW-1:0] v, output int lat);
    @(negedge clk);
    score       = v;
    score_valid = 1'b1;
    @(posedge clk);
    #1 score_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic probe(input logic [1:0] s, input logic [1:0] c, input logic [2:0] r,
                       output logic p);
    @(negedge clk);
    digit_sel = s;
    pix_col   = c;
    pix_row   = r;
    @(posedge clk);
    #1 p = pix_on;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   ndone;
    logic p;
    logic exp_p;

    vecs[0]  = '{14'd1234,  16'h1234, 2'd1, 2'd0, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{14'd1234,  16'h1234, 2'd1, 2'd0, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{14'd12000, 16'h9999, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{14'd9999,  16'h9999, 2'd3, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[4]  = '{14'd0,     16'h0000, 2'd0, 2'd1, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{14'd10000, 16'h9999, 2'd2, 2'd3, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{14'd16383, 16'h9999, 2'd1, 2'd0, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{14'd7,     16'h0007, 2'd0, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[8]  = '{14'd5678,  16'h5678, 2'd2, 2'd2, 3'd4, 1'b1, 1'b0};
    vecs[9]  = '{14'd4096,  16'h4096, 2'd3, 2'd0, 3'd2, 1'b1, 1'b0};
    vecs[10] = '{14'd808,   16'h0808, 2'd3, 2'd0, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{14'd2,     16'h0002, 2'd0, 2'd2, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{14'd1,     16'h0001, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0};

    // Reset state, with pixel inputs addressing a lit pixel of digit 0.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd",   32'(bcd), 32'h0);
    check("rst_pix",   32'(pix_on), 32'h0);
    check("rst_ready", 32'(score_ready), 32'h1);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("pix_after_rst", 32'(pix_on), 32'h1);

    // Vector table: latency, committed BCD and one pixel probe each.
    for (int i = 0; i < 13; i++) begin
      convert(vecs[i].val, lat);
      check($sformatf("lat_%0d", i), 32'(lat), 32'd15);
      check($sformatf("bcd_%0d", i), 32'(bcd), 32'(vecs[i].exp_bcd));
      probe(vecs[i].sel, vecs[i].col, vecs[i].row, p);
      exp_p = vecs[i].exp_pix;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
      if (vecs[i].lead) exp_p = 1'b0;
`endif
      check($sformatf("pix_%0d", i), 32'(p), 32'(exp_p));
    end

    // pix_on is registered: changing coordinates does not affect it before the edge.
    convert(14'd1234, lat);
    probe(2'd1, 2'd0, 3'd0, p);
    check("pix_reg_lit", 32'(p), 32'h1);
    @(negedge clk);
    pix_row = 3'd1;
    #1 check("pix_reg_hold", 32'(pix_on), 32'h1);
    @(posedge clk);
    #1 check("pix_reg_upd", 32'(pix_on), 32'h0);
    check("done_one_cycle", 32'(done), 32'h0);

    // Busy rejection: 77 offered mid-conversion is dropped.
    @(negedge clk);
    score       = 14'd55;
    score_valid = 1'b1;
    @(posedge clk);
    #1 score_valid = 1'b0;
    check("acc_busy",  32'(busy), 32'h1);
    check("acc_ready", 32'(score_ready), 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    score       = 14'd77;
    score_valid = 1'b1;
    @(posedge clk);
    #1 score_valid = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("rej_done_cnt", 32'(ndone), 32'd1);
    check("rej_bcd",      32'(bcd), 32'h0055);
    check("rej_ready",    32'(score_ready), 32'h1);
    check("rej_busy",     32'(busy), 32'h0);

    // Reset mid-conversion clears the display and aborts.
    @(negedge clk);
    score       = 14'd1234;
    score_valid = 1'b1;
    @(posedge clk);
    #1 score_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_bcd",   32'(bcd), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_ready", 32'(score_ready), 32'h1);
    check("mid_rst_done",  32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    check("mid_rst_bcd_after", 32'(bcd), 32'h0);
    check("mid_rst_idle", 32'(score_ready), 32'h1);

    // Leading-zero handling for a single-digit score.
    convert(14'd7, lat);
    check("lead_lat", 32'(lat), 32'd15);
    probe(2'd3, 2'd0, 3'd2, p);
`ifdef SCORE_LEAD_ZERO_BLANK_EN
    check("lead_blank", 32'(p), 32'h0);
`else
    check("lead_blank", 32'(p), 32'h1);
`endif
    probe(2'd0, 2'd0, 3'd0, p);
    check("lead_digit0", 32'(p), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_digits_render.md
SCORE_DIGITS_RENDER -- requirements
Module: score_digits_render

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, the number of decimal digits displayed (1..8).
REQ-002 SHALL have parameter SCORE_W, default 14, the binary score width in bits (1..27).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port score_valid, input, 1 bit: a new score is offered.
REQ-006 SHALL have port score, input, SCORE_W bits: the unsigned binary score.
REQ-007 SHALL have port score_ready, output, 1 bit: the block can accept a score.
REQ-008 SHALL have port busy, output, 1 bit: a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a new value is committed to the display.
REQ-010 SHALL have port bcd, output, 4*NUM_DIGITS bits: the committed BCD digits; nibble 0 is least significant.
REQ-011 SHALL have port digit_sel, input, $clog2(NUM_DIGITS) bits (minimum 1): the digit being drawn; 0 is least significant.
REQ-012 SHALL have port pix_col, input, 2 bits: glyph column 0..3.
REQ-013 SHALL have port pix_row, input, 3 bits: glyph row 0..4; row 0 is the top.
REQ-014 SHALL have port pix_on, output, 1 bit: the glyph pixel is lit.

Function
REQ-015 SHALL use a state machine with states IDLE, CONVERT and COMMIT; score_ready is 1 only in IDLE, and busy is 1 in CONVERT and COMMIT.
REQ-016 SHALL, in IDLE with score_valid=1, capture score, clear the BCD shift register, load the bit counter with SCORE_W, and go to CONVERT.
REQ-017 SHALL, in CONVERT, each cycle add 3 to every BCD nibble >=5 and then shift the register left by one, inserting the score MSB; after SCORE_W cycles it goes to COMMIT.
REQ-018 SHALL, in COMMIT, write the result to the display register driving bcd, pulse done=1, and return to IDLE; done therefore rises SCORE_W+1 cycles after the accept edge.
REQ-019 SHALL ignore score_valid while busy=1; it is not queued.
REQ-020 SHALL commit all nibbles as 9 if the captured score >= 10^NUM_DIGITS (saturation).
REQ-021 SHALL hold bcd stable until COMMIT; there is no partial update.
REQ-022 SHALL register pix_on with one-cycle latency from digit_sel/pix_col/pix_row, independent of the state machine, and read the committed display register.
REQ-023 SHALL make pix_on 0 when pix_col=3, pix_row>4 or digit_sel>=NUM_DIGITS.
REQ-024 SHALL use glyphs given as columns 0/1/2, each a row0..row4 bit string: 0=11111/10001/11111; 1=00000/00000/11111; 2=10111/10101/11101; 3=10101/10101/11111; 4=11100/00100/11111; 5=11101/10101/10111; 6=11111/10101/10111; 7=10001/10110/11000; 8=11111/10101/11111; 9=11101/10101/11111.
REQ-025 SHALL light all pixels in columns 0..2 for a nibble value >9 (unreachable; fail-safe block).

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, score_ready=1, busy=0, done=0, bcd=0 and pix_on=0.
REQ-027 SHALL, on reset mid-conversion, abort the conversion and clear the display register to 0.

Configuration
REQ-028 SHALL, with SCORE_LEAD_ZERO_BLANK_EN defined, render blank every digit above the highest nonzero digit; digit 0 is always drawn.
REQ-029 SHALL, without SCORE_LEAD_ZERO_BLANK_EN, draw all NUM_DIGITS digits, including leading zeros.

Structure
REQ-030 SHALL place the following in package score_digits_pkg: GLYPH_W=4, GLYPH_H=5, the 10-entry glyph constant table, and the state enum.
REQ-031 SHALL implement glyph lookup as one combinational sub-module, glyph_rom_5x4 (nibble, col, row -> bit).

Verification
REQ-032 SHALL cover reset: rst_n=0 -> bcd=0, pix_on=0, score_ready=1, busy=0.
REQ-033 SHALL cover conversion: score=1234 -> done 15 cycles after accept, bcd=16'h1234; digit_sel=1, col0 row1 -> pix_on=0 next cycle; col0 row0 -> 1.
REQ-034 SHALL cover saturation: score=12000 -> bcd=16'h9999.
REQ-035 SHALL cover busy rejection: score=55 accepted, score=77 offered mid-conversion -> bcd=16'h0055, one done pulse only.
REQ-036 SHALL cover reset mid-conversion: rst_n low at cycle 5 -> bcd=0, state IDLE, no done pulse.
REQ-037 SHALL cover leading blanking: score=7, digit_sel=3, col0 row2 -> pix_on=0 with SCORE_LEAD_ZERO_BLANK_EN, pix_on=1 without.
